ir_key_events: RTL

- Sits directly downstream of the NEC receiver (ir_rcv). Consumes each 32-bit frame it delivers and checks the NEC inverse bytes.
- Turns the stream of valid frames into debounced key PRESS/RELEASE events, using a release timeout and a small event FIFO.
- Feeds the UART/LED application logic through a valid/ready event interface.

---
 rtl/ir_pkg.sv | 27 ++
 rtl/ir_evt_fifo.sv | 50 +++++
 rtl/ir_key_events.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// Shared types for the NEC key-event path: event codes,
// FSM states, frame byte offsets and the FIFO entry layout.
package ir_pkg;

  localparam logic [1:0] EV_PRESS   = 2'b01;
  localparam logic [1:0] EV_RELEASE = 2'b10;

  localparam int ADDR_LSB  = 0;
  localparam int NADDR_LSB = 8;
  localparam int CMD_LSB   = 16;
  localparam int NCMD_LSB  = 24;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HELD = 2'd1,
    SWAP = 2'd2
  } state_t;

  typedef struct packed {
    logic [1:0]  typ;
    logic [15:0] addr;
    logic [7:0]  cmd;
  } ev_t;

  localparam int EV_W = $bits(ev_t);

endpackage

// File: rtl/ir_evt_fifo.sv
// Synchronous event FIFO; push/pop same cycle legal when full.
// Ports: clk, rst (async low), push/din, pop/dout, count.
module ir_evt_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          full;
  logic          empty;
  logic          wr;
  logic          rd;

  assign full  = count == CW'(DEPTH);
  assign empty = count == '0;
  assign rd    = pop && !empty;
  // a full FIFO still accepts a push when a pop frees the slot
  assign wr    = push && (!full || rd);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      count <= count + CW'(wr) - CW'(rd);
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  assign dout = mem[rp];

endmodule

// File: rtl/ir_key_events.sv
// NEC frame -> debounced PRESS/RELEASE events via a small FIFO.
// Ports: clk, rst (async low), burst/burst_vld in, ev_* valid/ready
// out, key_down, err_cnt, ovf. Define IR_EXT_ADDR_EN for 16-bit
// extended NEC addresses (no address inverse check).
module ir_key_events
  import ir_pkg::*;
#(
  parameter int CLK_HZ     = 100000000,
  parameter int RELEASE_MS = 120,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] burst,
  input  logic        burst_vld,
  output logic        ev_valid,
  input  logic        ev_ready,
  output logic [1:0]  ev_type,
  output logic [15:0] ev_addr,
  output logic [7:0]  ev_cmd,
  output logic        key_down,
  output logic [7:0]  err_cnt,
  output logic        ovf
);

  localparam int RC = CLK_HZ / 1000 * RELEASE_MS;
  localparam int TW = $clog2(RC + 1);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [TW-1:0] RC_T = TW'(RC);

  state_t        state;
  state_t        nstate;
  logic [TW-1:0] timer;
  logic [TW-1:0] ntimer;
  logic [15:0]   key_addr;
  logic [15:0]   nkey_addr;
  logic [7:0]    key_cmd;
  logic [7:0]    nkey_cmd;
  logic          push_q;
  logic          npush;
  ev_t           push_ev;
  ev_t           nev;

  logic          cap_vld;
  logic [31:0]   cap;
  logic          take;
  logic          drop;

  logic [7:0]    f_cmd;
  logic [7:0]    f_ncmd;
  logic [15:0]   f_addr;
  logic          ok;
  logic          f_ok;
  logic          bad;
  logic          same;

  ev_t           head;
  logic [CW-1:0] cnt;
  logic          full;
  logic          pop;
  logic [8:0]    err_sum;

  // a strobe is lost if the previous frame is still unprocessed
  // or the FSM is busy emitting the PRESS half of a key change
  assign take = burst_vld && !cap_vld && (state != SWAP);
  assign drop = burst_vld && !take;

  assign f_cmd  = cap[CMD_LSB +: 8];
  assign f_ncmd = cap[NCMD_LSB +: 8];

`ifdef IR_EXT_ADDR_EN
  assign f_addr = cap[ADDR_LSB +: 16];
  assign ok     = f_ncmd == ~f_cmd;
`else
  assign f_addr = {8'h00, cap[ADDR_LSB +: 8]};
  assign ok     = (f_ncmd == ~f_cmd) &&
                  (cap[NADDR_LSB +: 8] == ~cap[ADDR_LSB +: 8]);
`endif

  assign f_ok = cap_vld && ok;
  assign bad  = cap_vld && !ok;
  assign same = (f_addr == key_addr) && (f_cmd == key_cmd);

  always_comb begin
    nstate    = state;
    ntimer    = timer;
    nkey_addr = key_addr;
    nkey_cmd  = key_cmd;
    npush     = 1'b0;
    nev       = '0;
    unique case (state)
      IDLE: begin
        if (f_ok) begin
          npush     = 1'b1;
          nev.typ   = EV_PRESS;
          nev.addr  = f_addr;
          nev.cmd   = f_cmd;
          nkey_addr = f_addr;
          nkey_cmd  = f_cmd;
          ntimer    = RC_T;
          nstate    = HELD;
        end
      end
      HELD: begin
        // a matching frame beats an expiring timer
        if (f_ok && same) begin
          ntimer = RC_T;
        end else if (f_ok) begin
          npush     = 1'b1;
          nev.typ   = EV_RELEASE;
          nev.addr  = key_addr;
          nev.cmd   = key_cmd;
          nkey_addr = f_addr;
          nkey_cmd  = f_cmd;
          nstate    = SWAP;
        end else if (timer == '0) begin
          npush    = 1'b1;
          nev.typ  = EV_RELEASE;
          nev.addr = key_addr;
          nev.cmd  = key_cmd;
          nstate   = IDLE;
        end else begin
          ntimer = timer - 1'b1;
        end
      end
      SWAP: begin
        // key already holds the new frame's key
        npush    = 1'b1;
        nev.typ  = EV_PRESS;
        nev.addr = key_addr;
        nev.cmd  = key_cmd;
        ntimer   = RC_T;
        nstate   = HELD;
      end
      default: nstate = IDLE;
    endcase
  end

  assign err_sum = {1'b0, err_cnt} + 9'(drop) + 9'(bad);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      timer    <= '0;
      key_addr <= '0;
      key_cmd  <= '0;
      push_q   <= 1'b0;
      push_ev  <= '0;
      cap_vld  <= 1'b0;
      cap      <= '0;
      err_cnt  <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= nstate;
      timer    <= ntimer;
      key_addr <= nkey_addr;
      key_cmd  <= nkey_cmd;
      push_q   <= npush;
      push_ev  <= nev;
      cap_vld  <= take;
      if (take) cap <= burst;
      err_cnt  <= err_sum[8] ? 8'hFF : err_sum[7:0];
      if (push_q && full && !pop) ovf <= 1'b1;
    end
  end

  ir_evt_fifo #(
    .W     (EV_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_q),
    .din   (push_ev),
    .pop   (pop),
    .dout  (head),
    .count (cnt)
  );

  assign full     = cnt == CW'(FIFO_DEPTH);
  assign ev_valid = cnt != '0;
  assign pop      = ev_valid && ev_ready;

  // mask unreset storage so outputs read 0 when empty
  assign ev_type  = ev_valid ? head.typ  : 2'b00;
  assign ev_addr  = ev_valid ? head.addr : 16'h0000;
  assign ev_cmd   = ev_valid ? head.cmd  : 8'h00;
  assign key_down = (state == HELD) || (state == SWAP);

endmodule
